// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: upstream beat, forwarding source and ALU-side handshake.
// The master modport drives the stage inputs; the slave modport is the stage itself.
interface alu_operand_stage_if #(
  parameter int W     = 16,
  parameter int IMM_W = 5,
  parameter int RA_W  = 3
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_rd_a;
  logic [W-1:0]     in_rd_b;
  logic [RA_W-1:0]  in_src_a;
  logic [RA_W-1:0]  in_src_b;
  logic [1:0]       in_shift;
  logic             in_asel;
  logic             in_bsel;
  logic [IMM_W-1:0] in_imm;
  logic [1:0]       in_alu_op;
  logic [RA_W-1:0]  in_dst;
  logic             fw_valid;
  logic [RA_W-1:0]  fw_dst;
  logic [W-1:0]     fw_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     val_A;
  logic [W-1:0]     val_B;
  logic [1:0]       ALU_op;
  logic [RA_W-1:0]  out_dst;

  modport master (
    output flush, in_valid, in_rd_a, in_rd_b, in_src_a, in_src_b, in_shift,
           in_asel, in_bsel, in_imm, in_alu_op, in_dst,
           fw_valid, fw_dst, fw_data, out_ready,
    input  in_ready, out_valid, val_A, val_B, ALU_op, out_dst
  );

  modport slave (
    input  flush, in_valid, in_rd_a, in_rd_b, in_src_a, in_src_b, in_shift,
           in_asel, in_bsel, in_imm, in_alu_op, in_dst,
           fw_valid, fw_dst, fw_data, out_ready,
    output in_ready, out_valid, val_A, val_B, ALU_op, out_dst
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: forwarding, B shifter and imm/zero selects feeding a
// 2-entry skid buffer whose main entry directly drives the ALU-side outputs.
module alu_operand_stage #(
  parameter int W     = 16,
  parameter int IMM_W = 5,
  parameter int RA_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  alu_operand_stage_if.slave  bus
);
  localparam int BW = 2*W + 2 + RA_W;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] main_q, main_d;
  logic [BW-1:0] skid_q, skid_d;

  logic [W-1:0]  fwd_a, fwd_b, shifted_b, imm_ext, op_a, op_b;
  logic [BW-1:0] beat_new;
  logic          acc, pop;

  // Forwarding sits ahead of every mux so a writeback hit wins over stale regfile data.
  assign fwd_a = (bus.fw_valid && bus.fw_dst == bus.in_src_a) ? bus.fw_data : bus.in_rd_a;
  assign fwd_b = (bus.fw_valid && bus.fw_dst == bus.in_src_b) ? bus.fw_data : bus.in_rd_b;

  always_comb begin
    case (bus.in_shift)
      2'b01:   shifted_b = {fwd_b[W-2:0], 1'b0};
      2'b10:   shifted_b = {1'b0, fwd_b[W-1:1]};
      2'b11:   shifted_b = {fwd_b[W-1], fwd_b[W-1:1]};
      default: shifted_b = fwd_b;
    endcase
  end

  assign imm_ext  = {{(W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};
  assign op_a     = bus.in_asel ? '0 : fwd_a;
  assign op_b     = bus.in_bsel ? imm_ext : shifted_b;
  assign beat_new = {op_a, op_b, bus.in_alu_op, bus.in_dst};

  assign bus.in_ready  = (state_q != FULL) && !bus.flush;
  assign bus.out_valid = (state_q != EMPTY);
  assign acc = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;

  assign {bus.val_A, bus.val_B, bus.ALU_op, bus.out_dst} = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush only drops occupancy; the main entry keeps its last contents visible.
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_d  = beat_new;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_d = beat_new;
          end else if (acc) begin
            skid_d  = beat_new;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: datapath selects, forwarding,
// skid-buffer backpressure, flush and asynchronous reset.
module tb_alu_operand_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_operand_stage_if #(.W(16), .IMM_W(5), .RA_W(3)) bus ();

  alu_operand_stage #(.W(16), .IMM_W(5), .RA_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s: observed %h", tag, obs);
    end else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_rd_a   = '0;
    bus.in_rd_b   = '0;
    bus.in_src_a  = '0;
    bus.in_src_b  = '0;
    bus.in_shift  = 2'b00;
    bus.in_asel   = 1'b0;
    bus.in_bsel   = 1'b0;
    bus.in_imm    = '0;
    bus.in_alu_op = 2'b00;
    bus.in_dst    = '0;
    bus.fw_valid  = 1'b0;
    bus.fw_dst    = '0;
    bus.fw_data   = '0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_val_A",     32'(bus.val_A),     32'h0);
    check("rst_val_B",     32'(bus.val_B),     32'h0);
    check("rst_alu_op",    32'(bus.ALU_op),    32'h0);
    check("rst_out_dst",   32'(bus.out_dst),   32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // pass-through beat
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.in_rd_a = 16'd37; bus.in_rd_b = 16'hFFFB; bus.in_alu_op = 2'b00; bus.in_dst = 3'd2;
    step();
    check("pass_val_A",     32'(bus.val_A),     32'd37);
    check("pass_val_B",     32'(bus.val_B),     32'hFFFB);
    check("pass_alu_op",    32'(bus.ALU_op),    32'h0);
    check("pass_out_dst",   32'(bus.out_dst),   32'h2);
    check("pass_out_valid", 32'(bus.out_valid), 32'h1);

    // shifter
    bus.in_rd_b = 16'h8002; bus.in_alu_op = 2'b01;
    bus.in_shift = 2'b01; step();
    check("shift_lsl1", 32'(bus.val_B), 32'h0004);
    check("shift_op",   32'(bus.ALU_op), 32'h1);
    bus.in_shift = 2'b10; step();
    check("shift_lsr1", 32'(bus.val_B), 32'h4001);
    bus.in_shift = 2'b11; step();
    check("shift_asr1", 32'(bus.val_B), 32'hC001);

    // immediate and zero selects
    bus.in_shift = 2'b11; bus.in_bsel = 1'b1; bus.in_imm = 5'b10011;
    bus.in_asel = 1'b1; bus.in_rd_a = 16'h1234;
    step();
    check("imm_val_B",  32'(bus.val_B), 32'hFFF3);
    check("zero_val_A", 32'(bus.val_A), 32'h0000);

    // forwarding
    bus.in_asel = 1'b0; bus.in_bsel = 1'b0; bus.in_shift = 2'b01;
    bus.fw_valid = 1'b1; bus.fw_dst = 3'd3; bus.fw_data = 16'h1234;
    bus.in_src_b = 3'd3; bus.in_rd_b = 16'h0000;
    bus.in_src_a = 3'd1; bus.in_rd_a = 16'h0011;
    step();
    check("fwd_val_B",    32'(bus.val_B), 32'h2468);
    check("fwd_a_nohit",  32'(bus.val_A), 32'h0011);
    bus.in_src_a = 3'd3;
    step();
    check("fwd_val_A", 32'(bus.val_A), 32'h1234);
    bus.fw_valid = 1'b0;
    step();
    check("nofwd_val_B", 32'(bus.val_B), 32'h0000);
    check("nofwd_val_A", 32'(bus.val_A), 32'h0011);
    bus.in_valid = 1'b0;
    step();
    check("drain_out_valid", 32'(bus.out_valid), 32'h0);
    check("drain_hold_A",    32'(bus.val_A),     32'h0011);

    // backpressure: beats 1,2,3 offered while the ALU stalls
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_rd_a = 16'd1;
    step();
    bus.in_rd_a = 16'd2;
    step();
    check("bp_in_ready_full", 32'(bus.in_ready), 32'h0);
    bus.in_rd_a = 16'd3;
    step();
    check("bp_head1",  32'(bus.val_A),     32'd1);
    check("bp_valid1", 32'(bus.out_valid), 32'h1);
    bus.out_ready = 1'b1;
    step();
    check("bp_head2", 32'(bus.val_A), 32'd2);
    check("bp_in_ready_one", 32'(bus.in_ready), 32'h1);
    step();
    check("bp_head3", 32'(bus.val_A), 32'd3);
    bus.in_valid = 1'b0;
    step();
    check("bp_no_dup", 32'(bus.out_valid), 32'h0);

    // flush with a full buffer and a beat on offer
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_rd_a = 16'd4;
    step();
    bus.in_rd_a = 16'd5;
    step();
    bus.flush = 1'b1; bus.in_rd_a = 16'd6;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    check("flush_out_valid", 32'(bus.out_valid), 32'h0);
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    check("postflush_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    check("flush_beat_dropped", 32'(bus.out_valid), 32'h0);
    check("flush_hold_A",       32'(bus.val_A),     32'd4);

    // asynchronous reset mid-stream
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_rd_a = 16'd7; bus.in_rd_b = 16'd9; bus.in_alu_op = 2'b10; bus.in_dst = 3'd5;
    step();
    bus.in_valid = 1'b0;
    check("pre_rst_val_B", 32'(bus.val_B),   32'd9);
    check("pre_rst_dst",   32'(bus.out_dst), 32'd5);
    #1;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'h0);
    check("arst_val_A",     32'(bus.val_A),     32'h0);
    check("arst_val_B",     32'(bus.val_B),     32'h0);
    check("arst_alu_op",    32'(bus.ALU_op),    32'h0);
    check("arst_out_dst",   32'(bus.out_dst),   32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("arst_stays_empty", 32'(bus.out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
